// File: rtl/key_filter.sv
// Two-channel active-low key debouncer: 2-FF synchroniser, per-key stability counter, registered press pulses.
// Optional key_release port and pulses are built in when KEY_RELEASE_FLAG_EN is defined.
module key_filter #(
  parameter int CNT_MAX = 999_999
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [1:0] key_in,
  output logic [1:0] key_out,
`ifdef KEY_RELEASE_FLAG_EN
  output logic [1:0] key_release,
`endif
  output logic [1:0] key_press
);

  localparam int CNT_W = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(CNT_MAX);

  logic [1:0]       key_s1;
  logic [1:0]       key_s2;
  logic [CNT_W-1:0] cnt [2];

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      key_s1    <= 2'b11;
      key_s2    <= 2'b11;
      key_out   <= 2'b11;
      key_press <= 2'b00;
`ifdef KEY_RELEASE_FLAG_EN
      key_release <= 2'b00;
`endif
      cnt[0]    <= '0;
      cnt[1]    <= '0;
    end else begin
      key_s1    <= key_in;
      key_s2    <= key_s1;
      key_press <= 2'b00;
`ifdef KEY_RELEASE_FLAG_EN
      key_release <= 2'b00;
`endif
      for (int i = 0; i < 2; i++) begin
        // Any return to the accepted level restarts the stability window.
        if (key_s2[i] == key_out[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] != CNT_TOP) begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end else begin
          key_out[i]   <= key_s2[i];
          cnt[i]       <= '0;
          key_press[i] <= ~key_s2[i];
`ifdef KEY_RELEASE_FLAG_EN
          key_release[i] <= key_s2[i];
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_key_filter.sv
// Directed bench for key_filter (CNT_MAX=9): expected output events are queued when keys are driven
// and matched, including their arrival cycle, by a negedge monitor.
module tb_key_filter;

  localparam int CNT_MAX = 9;
  localparam int LAT     = CNT_MAX + 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] key_in = 2'b11;
  logic [1:0] key_out;
  logic [1:0] key_press;
  logic [1:0] rel_obs;

  typedef struct packed {
    logic [1:0] out;
    logic [1:0] press;
    logic [1:0] rel;
    int         cyc;
  } ev_t;

  ev_t        sb [$];
  int         cyc = 0;
  int         checks = 0;
  int         fails = 0;
  bit         mon_en = 1'b0;
  logic [1:0] prev_out;

`ifdef KEY_RELEASE_FLAG_EN
  logic [1:0] key_release;
  key_filter #(.CNT_MAX(CNT_MAX)) dut (
    .sys_clk(clk), .sys_rst_n(rst_n), .key_in(key_in),
    .key_out(key_out), .key_release(key_release), .key_press(key_press)
  );
  assign rel_obs = key_release;
`else
  key_filter #(.CNT_MAX(CNT_MAX)) dut (
    .sys_clk(clk), .sys_rst_n(rst_n), .key_in(key_in),
    .key_out(key_out), .key_press(key_press)
  );
  assign rel_obs = 2'b00;
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      fails = fails + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_ev(input logic [1:0] out, input logic [1:0] press, input logic [1:0] rel);
    ev_t e;
    e.out   = out;
    e.press = press;
    e.rel   = rel;
    e.cyc   = cyc + LAT;
    sb.push_back(e);
  endtask

  // Called on a negedge; leaves key_in at v for n cycles.
  task automatic hold(input logic [1:0] v, input int n);
    key_in = v;
    repeat (n) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (key_out !== prev_out || key_press !== 2'b00 || rel_obs !== 2'b00) begin
        if (sb.size() == 0) begin
          check("spurious_event", {26'd0, key_out, key_press, rel_obs}, {26'd0, prev_out, 4'b0000});
        end else begin
          ev_t e;
          e = sb.pop_front();
          check("ev_key_out", 32'(key_out), 32'(e.out));
          check("ev_key_press", 32'(key_press), 32'(e.press));
`ifdef KEY_RELEASE_FLAG_EN
          check("ev_key_release", 32'(rel_obs), 32'(e.rel));
`endif
          check("ev_cycle", cyc, e.cyc);
        end
      end
      prev_out = key_out;
    end
  end

  initial begin
    // 1: reset with keys idle, then quiet for 50 cycles
    rst_n  = 1'b0;
    key_in = 2'b11;
    repeat (3) @(negedge clk);
    check("rst_key_out", 32'(key_out), 32'h3);
    check("rst_key_press", 32'(key_press), 32'h0);
    check("rst_rel", 32'(rel_obs), 32'h0);
    check("rst_cnt0", 32'(dut.cnt[0]), 32'h0);
    check("rst_cnt1", 32'(dut.cnt[1]), 32'h0);
    rst_n    = 1'b1;
    prev_out = key_out;
    mon_en   = 1'b1;
    hold(2'b11, 50);
    check("idle_key_out", 32'(key_out), 32'h3);

    // 2: right key pressed and held
    expect_ev(2'b10, 2'b01, 2'b00);
    hold(2'b10, 20);

    // 3: left key glitches never accepted, then a real press after the last fall
    hold(2'b00, 5);
    hold(2'b10, 3);
    hold(2'b00, 3);
    hold(2'b10, 2);
    hold(2'b00, 4);
    hold(2'b10, 2);
    check("glitch_key_out", 32'(key_out), 32'h2);
    expect_ev(2'b00, 2'b10, 2'b00);
    hold(2'b00, 20);

    // back to idle before the simultaneous test
    expect_ev(2'b11, 2'b00, 2'b11);
    hold(2'b11, 20);

    // 4: both keys together, press then release
    expect_ev(2'b00, 2'b11, 2'b00);
    hold(2'b00, 20);
    expect_ev(2'b11, 2'b00, 2'b11);
    hold(2'b11, 20);

    // 5: reset mid-count aborts the pending press; count restarts at release
    hold(2'b10, 8);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_key_out", 32'(key_out), 32'h3);
    check("midrst_cnt0", 32'(dut.cnt[0]), 32'h0);
    rst_n = 1'b1;
    expect_ev(2'b10, 2'b01, 2'b00);
    hold(2'b10, 20);

    check("sb_drained", sb.size(), 32'd0);
    check("final_key_out", 32'(key_out), 32'h2);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
